// File: rtl/hub75_bcm_scan.sv
// ---------------------------------------------------------------------------
// hub75_bcm_scan
//
// HUB75 panel scan engine with binary-coded modulation. For each scan row it
// shifts BITS bit planes out of an external framebuffer (one pixel word per
// column, fixed read latency), latches each plane and shows it for
// BASE_ON << plane clk cycles. The row-select chain is clocked once per row,
// ahead of that row's first plane. At every frame end a pending swap request
// flips the displayed framebuffer half.
//
// Ports
//   clk, rst      system clock, synchronous active-low reset
//   en            run enable, only acted on between frames
//   swap_req      level request to flip the displayed buffer half
//   swap_ack      one-cycle pulse when the flip happens
//   buf_sel       framebuffer half currently displayed
//   rd_en/rd_addr framebuffer read strobe and {buf_sel, row, col} address
//   rd_data       pixel word; channel k colour c at [(k*3+c)*BITS +: BITS]
//   rgb           current bit plane, pin k*3+c
//   clk_out, lat, blank   panel shift clock, latch, output disable (1 = dark)
//   row_clk, row_data     row-select shift chain
//   frame_start   one-cycle pulse when a frame begins
// ---------------------------------------------------------------------------
module hub75_bcm_scan #(
   parameter int CH      = 4,
   parameter int COLS    = 64,
   parameter int ROWS    = 32,
   parameter int BITS    = 8,
   parameter int CLK_DIV = 2,
   parameter int RD_LAT  = 2,
   parameter int BASE_ON = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               en,
   input  logic                               swap_req,
   output logic                               swap_ack,
   output logic                               buf_sel,
   output logic                               rd_en,
   output logic [$clog2(ROWS)+$clog2(COLS):0] rd_addr,
   input  logic [CH*3*BITS-1:0]               rd_data,
   output logic [CH*3-1:0]                    rgb,
   output logic                               clk_out,
   output logic                               lat,
   output logic                               blank,
   output logic                               row_clk,
   output logic                               row_data,
   output logic                               frame_start
);

   localparam int RW     = $clog2(ROWS);
   localparam int CW     = $clog2(COLS);
   localparam int BW     = (BITS > 1) ? $clog2(BITS) : 1;
   localparam int PER    = 2 * CLK_DIV + RD_LAT + 1;
   localparam int ON_MAX = BASE_ON << (BITS - 1);
   localparam int T_MAX  = (PER > ON_MAX) ? PER : ON_MAX;
   localparam int TW     = $clog2(T_MAX + 1);

   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [TW-1:0] T_SAMPLE = TW'(RD_LAT);
   localparam logic [TW-1:0] T_RISE   = TW'(RD_LAT + CLK_DIV);
   localparam logic [TW-1:0] T_LAST   = TW'(PER - 1);
   localparam logic [TW-1:0] ON_BASE  = TW'(BASE_ON);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);

   typedef enum logic [2:0] {
      IDLE, SHIFT, ROWSEL, LATCH, DISPLAY, FRAME_END
   } state_t;

   state_t            state_q, state_d;
   // tmr is the column phase in SHIFT, the cycle index in ROWSEL and the
   // remaining on-time in DISPLAY.
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              buf_q, buf_d;
   logic [CH*3-1:0]   rgb_q, rgb_d;
   logic              fs_q, fs_d;
   logic              ack_q, ack_d;

   // Pick bit b of every colour component in the fetched pixel word.
   function automatic logic [CH*3-1:0] plane_of(input logic [CH*3*BITS-1:0] d,
                                               input logic [BW-1:0]         b);
      logic [BITS-1:0] w;
      for (int i = 0; i < CH * 3; i++) begin
         w           = d[i*BITS +: BITS];
         plane_of[i] = w[b];
      end
   endfunction

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d  = state_q;
      tmr_d    = tmr_q;
      col_d    = col_q;
      row_d    = row_q;
      bit_d    = bit_q;
      buf_d    = buf_q;
      rgb_d    = rgb_q;
      fs_d     = 1'b0;
      ack_d    = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = '0;
      clk_out  = 1'b0;
      lat      = 1'b0;
      blank    = 1'b1;
      row_clk  = 1'b0;
      row_data = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (en) begin
               fs_d    = 1'b1;
               row_d   = '0;
               bit_d   = '0;
               col_d   = '0;
               tmr_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            rd_en   = (tmr_q == '0);
            rd_addr = rd_en ? {buf_q, row_q, col_q} : '0;
            // Low half of clk_out covers the rgb update cycle, so data is
            // stable for CLK_DIV cycles before the rising edge.
            clk_out = (tmr_q > T_RISE);
            if (tmr_q == T_SAMPLE) begin
               rgb_d = plane_of(rd_data, bit_q);
            end
            if (tmr_q == T_LAST) begin
               tmr_d = '0;
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  // The row chain only advances ahead of a row's first plane.
                  state_d = (bit_q == '0) ? ROWSEL : LATCH;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end else begin
               tmr_d = tmr_q + T_ONE;
            end
         end

         ROWSEL: begin
            // A single 1 enters the chain at row 0 and ripples down.
            row_data = (row_q == '0);
            if (tmr_q == '0) begin
               tmr_d = T_ONE;
            end else begin
               row_clk = 1'b1;
               tmr_d   = '0;
               state_d = LATCH;
            end
         end

         LATCH: begin
            lat     = 1'b1;
            tmr_d   = (ON_BASE << bit_q) - T_ONE;
            state_d = DISPLAY;
         end

         DISPLAY: begin
            blank = 1'b0;
            if (tmr_q == '0) begin
               if (bit_q != BIT_LAST) begin
                  bit_d   = bit_q + BW'(1);
                  state_d = SHIFT;
               end else if (row_q != ROW_LAST) begin
                  bit_d   = '0;
                  row_d   = row_q + RW'(1);
                  state_d = SHIFT;
               end else begin
                  state_d = FRAME_END;
               end
            end else begin
               tmr_d = tmr_q - T_ONE;
            end
         end

         FRAME_END: begin
            if (swap_req) begin
               buf_d = ~buf_q;
               ack_d = 1'b1;
            end
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (!rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         bit_q   <= '0;
         buf_q   <= 1'b0;
         rgb_q   <= '0;
         fs_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         col_q   <= col_d;
         row_q   <= row_d;
         bit_q   <= bit_d;
         buf_q   <= buf_d;
         rgb_q   <= rgb_d;
         fs_q    <= fs_d;
         ack_q   <= ack_d;
      end
   end

   // Pulses are registered so they cannot be asserted while rst is low and
   // so swap_ack appears in the same cycle as the new buf_sel.
   assign frame_start = fs_q;
   assign swap_ack    = ack_q;
   assign buf_sel     = buf_q;
   assign rgb         = rgb_q;

endmodule
